// File: rtl/maze_pkg.sv
// Shared types and constants for the depth-first maze solver controller.
package maze_pkg;

  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int LOC_W = ROW_W + COL_W;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    CHECK,
    EVAL,
    BACK,
    POPW,
    TRACE,
    DONE,
    FAIL
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

endpackage

// File: rtl/maze_dfs_ctrl_nbr_calc.sv
// Combinational neighbour lookup: location one step away in a given direction,
// flagged invalid when the step would leave the grid.
module maze_nbr_calc
  import maze_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int COL_W = 4,
  localparam int LW = ROW_W + COL_W
) (
  input  logic [LW-1:0] cur_loc,
  input  logic [1:0]    dir,
  output logic [LW-1:0] nbr_loc,
  output logic          nbr_valid
);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  assign row = cur_loc[LW-1:COL_W];
  assign col = cur_loc[COL_W-1:0];

  always_comb begin
    nbr_loc   = cur_loc;
    nbr_valid = 1'b0;
    case (dir)
      DIR_UP: begin
        nbr_valid = (row != '0);
        nbr_loc   = {row - ROW_W'(1), col};
      end
      DIR_RIGHT: begin
        nbr_valid = (col != '1);
        nbr_loc   = {row, col + COL_W'(1)};
      end
      DIR_DOWN: begin
        nbr_valid = (row != '1);
        nbr_loc   = {row + ROW_W'(1), col};
      end
      default: begin
        nbr_valid = (col != '0);
        nbr_loc   = {row, col - COL_W'(1)};
      end
    endcase
  end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze solver controller driving the location stack and maze RAM.
// Define MAZE_PATH_TRACE_EN to replay the solved path on path_valid/path_loc.
module maze_dfs_ctrl
  import maze_pkg::*;
#(
  parameter int         ROW_W     = 4,
  parameter int         COL_W     = 4,
  parameter logic [7:0] START     = 8'h00,
  parameter logic [7:0] GOAL      = 8'hFF,
  parameter int         MAX_DEPTH = 63,
  localparam int        LW        = ROW_W + COL_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [LW-1:0] mem_addr,
  input  logic          mem_rdata,
  output logic          mem_we,
  output logic          mem_wdata,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [LW-1:0] stk_din,
  input  logic [LW-1:0] stk_dout,
  input  logic          stk_nonempty,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [LW-1:0] cur_loc
`ifdef MAZE_PATH_TRACE_EN
  ,
  output logic          path_valid,
  output logic [LW-1:0] path_loc
`endif
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [LW-1:0] START_LOC = START[LW-1:0];
  localparam logic [LW-1:0] GOAL_LOC  = GOAL[LW-1:0];

  state_t        state;
  logic [2:0]    dir;
  logic [DW-1:0] depth;
  logic          phase;
  logic [LW-1:0] nbr_loc;
  logic          nbr_valid;
  logic          room;

  maze_nbr_calc #(.ROW_W(ROW_W), .COL_W(COL_W)) u_nbr (
    .cur_loc  (cur_loc),
    .dir      (dir[1:0]),
    .nbr_loc  (nbr_loc),
    .nbr_valid(nbr_valid)
  );

  assign room      = (depth != DW'(MAX_DEPTH));
  assign mem_wdata = 1'b1;
  assign busy      = (state != IDLE);

  // phase splits two-cycle states: INIT read/decide, TRACE pop/emit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_loc <= START_LOC;
      dir     <= '0;
      depth   <= '0;
      phase   <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
`ifdef MAZE_PATH_TRACE_EN
      path_valid <= 1'b0;
      path_loc   <= '0;
`endif
    end else begin
`ifdef MAZE_PATH_TRACE_EN
      path_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            done    <= 1'b0;
            fail    <= 1'b0;
            cur_loc <= START_LOC;
            dir     <= '0;
            depth   <= '0;
            phase   <= 1'b0;
            state   <= INIT;
          end
        end
        INIT: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (mem_rdata) begin
              state <= FAIL;
            end else if (START_LOC == GOAL_LOC) begin
`ifdef MAZE_PATH_TRACE_EN
              path_valid <= 1'b1;
              path_loc   <= GOAL_LOC;
              state      <= TRACE;
`else
              state <= DONE;
`endif
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (dir == 3'd4) begin
            state <= BACK;
          end else if (!nbr_valid) begin
            dir <= dir + 3'd1;
          end else begin
            state <= EVAL;
          end
        end
        EVAL: begin
          if (mem_rdata) begin
            dir   <= dir + 3'd1;
            state <= CHECK;
          end else if (!room) begin
            state <= FAIL;
          end else begin
            cur_loc <= nbr_loc;
            dir     <= '0;
            depth   <= depth + DW'(1);
            if (nbr_loc == GOAL_LOC) begin
`ifdef MAZE_PATH_TRACE_EN
              path_valid <= 1'b1;
              path_loc   <= GOAL_LOC;
              phase      <= 1'b0;
              state      <= TRACE;
`else
              state <= DONE;
`endif
            end else begin
              state <= CHECK;
            end
          end
        end
        BACK: begin
          if (!stk_nonempty) begin
            state <= FAIL;
          end else begin
            depth <= depth - DW'(1);
            state <= POPW;
          end
        end
        POPW: begin
          cur_loc <= stk_dout;
          dir     <= '0;
          state   <= CHECK;
        end
`ifdef MAZE_PATH_TRACE_EN
        TRACE: begin
          if (!phase) begin
            if (stk_nonempty) begin
              depth <= depth - DW'(1);
              phase <= 1'b1;
            end else begin
              state <= DONE;
            end
          end else begin
            phase      <= 1'b0;
            path_valid <= 1'b1;
            path_loc   <= stk_dout;
          end
        end
`endif
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        FAIL: begin
          fail  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the current state; the EVAL write and push wait on the RAM bit
  always_comb begin
    mem_addr = nbr_loc;
    mem_we   = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_din  = cur_loc;
    case (state)
      INIT: begin
        mem_addr = START_LOC;
        mem_we   = phase && !mem_rdata;
      end
      EVAL: begin
        mem_we   = !mem_rdata && room;
        stk_push = !mem_rdata && room;
      end
      BACK: stk_pop = stk_nonempty;
`ifdef MAZE_PATH_TRACE_EN
      TRACE: stk_pop = !phase && stk_nonempty;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// Bench for maze_dfs_ctrl on a 4x4 grid: two instances (deep stack and MAX_DEPTH=3)
// with RAM/stack models, checked against a plain DFS reference model.
module tb_maze_dfs_ctrl;
  import maze_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]      start_v, mem_rdata_v, mem_we_v, mem_wdata_v;
  logic [N-1:0]      push_v, pop_v, nonempty_v, busy_v, done_v, fail_v;
  logic [N-1:0][3:0] addr_v, din_v, dout_v, cur_v;

  maze_dfs_ctrl #(.ROW_W(2), .COL_W(2), .START(8'h00), .GOAL(8'h0F), .MAX_DEPTH(63)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .mem_addr(addr_v[0]), .mem_rdata(mem_rdata_v[0]), .mem_we(mem_we_v[0]),
    .mem_wdata(mem_wdata_v[0]), .stk_push(push_v[0]), .stk_pop(pop_v[0]),
    .stk_din(din_v[0]), .stk_dout(dout_v[0]), .stk_nonempty(nonempty_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .fail(fail_v[0]), .cur_loc(cur_v[0])
  );

  maze_dfs_ctrl #(.ROW_W(2), .COL_W(2), .START(8'h00), .GOAL(8'h0F), .MAX_DEPTH(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .mem_addr(addr_v[1]), .mem_rdata(mem_rdata_v[1]), .mem_we(mem_we_v[1]),
    .mem_wdata(mem_wdata_v[1]), .stk_push(push_v[1]), .stk_pop(pop_v[1]),
    .stk_din(din_v[1]), .stk_dout(dout_v[1]), .stk_nonempty(nonempty_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .fail(fail_v[1]), .cur_loc(cur_v[1])
  );

  logic [15:0] maze     [N];
  logic [15:0] load_pat [N];
  logic        load_req;
  logic [3:0]  stkq     [N][$];
  int          push_cnt [N];
  int          pop_cnt  [N];
  int          wr_cnt   [N];
  int          reload_ok  [N];
  int          reload_bad [N];
  logic [1:0]  pend_v   [N];
  logic [3:0]  pend_val [N][2];

  // RAM and stack models; a popped value must show up on cur_loc two edges later
  always @(posedge clk) begin
    logic [3:0] v;
    for (int g = 0; g < N; g++) begin
      if (load_req) begin
        maze[g] <= load_pat[g];
        stkq[g].delete();
        push_cnt[g] = 0;
        pop_cnt[g] = 0;
        wr_cnt[g] = 0;
        reload_ok[g] = 0;
        reload_bad[g] = 0;
        pend_v[g] <= 2'b00;
        mem_rdata_v[g] <= 1'b0;
        dout_v[g] <= 4'h0;
        nonempty_v[g] <= 1'b0;
      end else begin
        mem_rdata_v[g] <= maze[g][addr_v[g]];
        if (mem_we_v[g]) begin
          maze[g][addr_v[g]] <= mem_wdata_v[g];
          wr_cnt[g]++;
        end
        if (pend_v[g][1]) begin
          if (cur_v[g] === pend_val[g][1]) reload_ok[g]++;
          else reload_bad[g]++;
        end
        pend_v[g] <= {pend_v[g][0], 1'b0};
        pend_val[g][1] <= pend_val[g][0];
        if (push_v[g]) begin
          stkq[g].push_back(din_v[g]);
          push_cnt[g]++;
        end
        if (pop_v[g]) begin
          v = (stkq[g].size() > 0) ? stkq[g].pop_back() : 4'h0;
          dout_v[g] <= v;
          pop_cnt[g]++;
          pend_v[g][0] <= 1'b1;
          pend_val[g][0] <= v;
        end
        nonempty_v[g] <= (stkq[g].size() > 0);
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain DFS over a 4x4 grid: try up/right/down/left, backtrack on dead ends
  function automatic void ref_solve(input logic [15:0] walls, input int max_depth,
                                    output bit ok, output int pushes, output int pops,
                                    output int depth, output int loc, output logic [15:0] image);
    int path[$];
    int dr[4] = '{-1, 0, 1, 0};
    int dc[4] = '{0, 1, 0, -1};
    bit moved;
    image = walls;
    pushes = 0;
    pops = 0;
    loc = 0;
    ok = 0;
    depth = 0;
    if (image[0]) return;
    image[0] = 1'b1;
    while (loc != 15) begin
      moved = 0;
      for (int d = 0; d < 4 && !moved; d++) begin
        int r, c, n;
        r = loc / 4 + dr[d];
        c = loc % 4 + dc[d];
        if (r < 0 || r > 3 || c < 0 || c > 3) continue;
        n = r * 4 + c;
        if (image[n]) continue;
        if (path.size() == max_depth) begin
          depth = path.size();
          return;
        end
        path.push_back(loc);
        pushes++;
        image[n] = 1'b1;
        loc = n;
        moved = 1;
      end
      if (!moved) begin
        if (path.size() == 0) return;
        loc = path.pop_back();
        pops++;
      end
    end
    ok = 1;
    depth = path.size();
  endfunction

  task automatic load_maze(input int sel, input logic [15:0] walls);
    @(negedge clk);
    load_pat[sel] = walls;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic apply_stimulus(input int sel);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  // Full solve on one instance, compared against the reference model
  task automatic run_solve(input int sel, input logic [15:0] walls, input string tag);
    bit ok;
    int pushes, pops, depth, loc, cyc;
    logic [15:0] image;
    load_maze(sel, walls);
    apply_stimulus(sel);
    cyc = 0;
    while (!(done_v[sel] || fail_v[sel]) && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    check_value({tag, " finished"}, 32'(cyc < 600), 32'd1);
    ref_solve(walls, (sel == 0) ? 63 : 3, ok, pushes, pops, depth, loc, image);
    check_value({tag, " done"}, 32'(done_v[sel]), 32'(ok));
    check_value({tag, " fail"}, 32'(fail_v[sel]), 32'(!ok));
    check_value({tag, " busy"}, 32'(busy_v[sel]), 32'd0);
    check_value({tag, " pushes"}, push_cnt[sel], pushes);
    check_value({tag, " pops"}, pop_cnt[sel], pops);
    check_value({tag, " stack"}, stkq[sel].size(), depth);
    check_value({tag, " cur_loc"}, 32'(cur_v[sel]), loc);
    check_value({tag, " image"}, 32'(maze[sel]), 32'(image));
    check_value({tag, " reload"}, reload_bad[sel], 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start_v = '0;
    load_req = 1'b0;
    load_pat[0] = 16'h0;
    load_pat[1] = 16'h0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check_value("reset busy", 32'(busy_v[g]), 32'd0);
      check_value("reset done", 32'(done_v[g]), 32'd0);
      check_value("reset fail", 32'(fail_v[g]), 32'd0);
      check_value("reset cur_loc", 32'(cur_v[g]), 32'd0);
      check_value("reset strobes", 32'({push_v[g], pop_v[g], mem_we_v[g]}), 32'd0);
    end
    rst = 1'b0;

    run_solve(0, 16'h0000, "open");
    check_value("open pushes=6", push_cnt[0], 6);
    check_value("open pops=0", pop_cnt[0], 0);
    check_value("open cur=F", 32'(cur_v[0]), 32'hF);
    check_value("open done", 32'(done_v[0]), 32'd1);

    run_solve(0, 16'h0001, "start_wall");
    check_value("start_wall fail", 32'(fail_v[0]), 32'd1);
    check_value("start_wall no push", push_cnt[0], 0);
    check_value("start_wall no write", wr_cnt[0], 0);

    run_solve(0, 16'h00E0, "dead_end");
    check_value("dead_end popped", 32'(pop_cnt[0] > 0), 32'd1);
    check_value("dead_end reloads", 32'(reload_ok[0] > 0), 32'd1);
    check_value("dead_end done", 32'(done_v[0]), 32'd1);

    run_solve(0, 16'h4800, "goal_walled");
    check_value("goal_walled fail", 32'(fail_v[0]), 32'd1);
    check_value("goal_walled drained", stkq[0].size(), 0);

    run_solve(1, 16'h0000, "depth3");
    check_value("depth3 fail", 32'(fail_v[1]), 32'd1);
    check_value("depth3 pushes=3", push_cnt[1], 3);

    // Abort mid-solve: reset while the first EVAL is in progress
    load_maze(0, 16'h0000);
    apply_stimulus(0);
    cyc = 0;
    while (dut0.state != EVAL && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_value("reach EVAL", 32'(cyc < 50), 32'd1);
    rst = 1'b1;
    #1;
    check_value("abort busy", 32'(busy_v[0]), 32'd0);
    check_value("abort cur_loc", 32'(cur_v[0]), 32'd0);
    check_value("abort strobes", 32'({push_v[0], pop_v[0], mem_we_v[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_solve(0, 16'h0000, "rerun");
    check_value("rerun done", 32'(done_v[0]), 32'd1);

    for (int i = 0; i < 10; i++) begin
      logic [15:0] w;
      w = 16'($urandom & $urandom) & 16'h7FFE;
      run_solve(i % 2, w, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
